// File: rtl/regs_read_seq.sv
// Operand read sequencer for a 1R/1W registered-read register memory, with write-back forwarding.
// Build option: define REGS_READ_SEQ_ZERO_EN to hardwire register 0 to zero.
module regs_read_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

`ifdef REGS_READ_SEQ_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, OUT} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rs_l_q, rt_l_q;
    logic                fwd_rs_q, fwd_rt_q;
    logic [DATA_W-1:0]   fwd_rs_data_q, fwd_rt_data_q;
    logic [DATA_W-1:0]   rs_data_q, rt_data_q;
    logic                op_valid_q;

    logic                wb_commit;
    logic                hit_rs, hit_rt;
    logic                rs_zero, rt_zero;
    logic [DATA_W-1:0]   rs_load_d, rt_load_d;

    // A write to the hardwired-zero register never reaches memory, so it can never hit either.
    assign wb_commit = wb_valid && !(ZERO_EN && (wb_addr == '0));
    assign hit_rs    = wb_commit && (wb_addr == rs_l_q);
    assign hit_rt    = wb_commit && (wb_addr == rt_l_q);
    assign rs_zero   = ZERO_EN && (rs_l_q == '0);
    assign rt_zero   = ZERO_EN && (rt_l_q == '0);

    // Freshest value: same-cycle write, then an earlier forwarded write, then memory.
    always_comb begin
        rs_load_d = mem_q;
        if (hit_rs)
            rs_load_d = wb_data;
        else if (fwd_rs_q)
            rs_load_d = fwd_rs_data_q;
        if (rs_zero)
            rs_load_d = '0;

        rt_load_d = mem_q;
        if (hit_rt)
            rt_load_d = wb_data;
        else if (fwd_rt_q)
            rt_load_d = fwd_rt_data_q;
        if (rt_zero)
            rt_load_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rs_l_q        <= '0;
            rt_l_q        <= '0;
            fwd_rs_q      <= 1'b0;
            fwd_rt_q      <= 1'b0;
            fwd_rs_data_q <= '0;
            fwd_rt_data_q <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            op_valid_q    <= 1'b0;
        end else begin
            if (state_q == RD_A || state_q == RD_B || state_q == CAP) begin
                if (hit_rs) begin
                    fwd_rs_q      <= 1'b1;
                    fwd_rs_data_q <= wb_data;
                end
                if (hit_rt) begin
                    fwd_rt_q      <= 1'b1;
                    fwd_rt_data_q <= wb_data;
                end
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rs_l_q   <= rs_addr;
                        rt_l_q   <= rt_addr;
                        fwd_rs_q <= 1'b0;
                        fwd_rt_q <= 1'b0;
                        state_q  <= RD_A;
                    end
                end
                RD_A: state_q <= RD_B;
                RD_B: begin
                    rs_data_q <= rs_load_d;
                    state_q   <= CAP;
                end
                CAP: begin
                    rt_data_q <= rt_load_d;
                    if (hit_rs && !rs_zero)
                        rs_data_q <= wb_data;
                    op_valid_q <= 1'b1;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign op_valid    = op_valid_q;
    assign rs_data     = rs_data_q;
    assign rt_data     = rt_data_q;
    assign mem_rd_addr = (state_q == RD_B) ? rt_l_q : rs_l_q;
    assign mem_wr_addr = wb_addr;
    assign mem_d       = wb_data;
    assign mem_we      = wb_commit && !reset;

endmodule
